// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: latches a 14-bit count per frame, converts to BCD and scans a 4-digit common-anode FND
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] count,
  input  logic        blank_lead,
  input  logic [3:0]  dp_en,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_font
);
  localparam int PW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t      state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [1:0]  idx_q;
  logic [29:0] sh_q, sh_d;
  logic [3:0]  bit_q, bit_d;
  logic        pend_q, pend_d;
  logic        oor_q, oor_d;
  logic [15:0] disp_q, disp_d;
  logic        disp_oor_q, disp_oor_d;
  logic [3:0]  com_q, com_d;
  logic [7:0]  font_q, font_d;
  logic [15:0] adj;
  logic [3:0]  digit;
  logic [3:0]  lz;
  logic        scan_tick, frame;

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 8'hC0;
      4'd1: seg = 8'hF9;
      4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;
      4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;
      4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  assign scan_tick = presc_q == PW'(SCAN_DIV - 1);
  assign frame     = scan_tick && idx_q == 2'd3;
  assign lz[3]     = disp_q[15:12] == 4'd0;
  assign lz[2]     = lz[3] && disp_q[11:8] == 4'd0;
  assign lz[1]     = lz[2] && disp_q[7:4] == 4'd0;
  assign lz[0]     = 1'b0;
  assign digit     = disp_q[4*idx_q +: 4];
  assign fnd_com   = com_q;
  assign fnd_font  = font_q;

  // slot timing: prescaler wraps every SCAN_DIV cycles, digit index steps once per wrap
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
    end else begin
      presc_q <= scan_tick ? '0 : presc_q + PW'(1);
      idx_q   <= idx_q + 2'(scan_tick);
    end

  // conversion and display state; pending start forces a conversion right after reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bit_q      <= 4'd0;
      pend_q     <= 1'b1;
      oor_q      <= 1'b0;
      disp_q     <= '0;
      disp_oor_q <= 1'b0;
      com_q      <= 4'b1111;
      font_q     <= 8'hFF;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      pend_q     <= pend_d;
      oor_q      <= oor_d;
      disp_q     <= disp_d;
      disp_oor_q <= disp_oor_d;
      com_q      <= com_d;
      font_q     <= font_d;
    end

  // add-3 correction applied to every BCD nibble before each shift
  always_comb
    for (int k = 0; k < 4; k++)
      adj[4*k +: 4] = sh_q[14+4*k +: 4] >= 4'd5 ? sh_q[14+4*k +: 4] + 4'd3 : sh_q[14+4*k +: 4];

  // double-dabble FSM: latch on frame boundary, 14 shift iterations, then publish
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    pend_d     = pend_q;
    oor_d      = oor_q;
    disp_d     = disp_q;
    disp_oor_d = disp_oor_q;
    case (state_q)
      IDLE: if (frame || pend_q) begin
        sh_d    = {16'd0, count};
        oor_d   = count > 14'd9999;
        pend_d  = 1'b0;
        bit_d   = 4'd0;
        state_d = CONV;
      end
      CONV: begin
        sh_d    = 30'({adj, sh_q[13:0]} << 1);
        bit_d   = bit_q == 4'd14 ? bit_q : bit_q + 4'd1;
        state_d = bit_q == 4'd13 ? DONE : CONV;
      end
      DONE: begin
        disp_d     = sh_q[29:14];
        disp_oor_d = oor_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // segment pattern for the current digit; dp overrides even dash or blank
  always_comb begin
    com_d     = ~(4'b0001 << idx_q);
    font_d    = disp_oor_q ? 8'hBF : (blank_lead && lz[idx_q]) ? 8'hFF : seg(digit);
    font_d[7] = font_d[7] & ~dp_en[idx_q];
  end
endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller: scoreboard bench checking scanned digit patterns per slot
module tb_fnd_scan_controller;
  localparam int DIV = 40;
  localparam logic [7:0] TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  typedef struct {logic [3:0] com; logic [7:0] font; int slot;} exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [13:0] count = 14'd0;
  logic        blank_lead = 1'b0;
  logic [3:0]  dp_en = 4'd0;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_font;
  exp_t        q[$];
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .count(count), .blank_lead(blank_lead),
    .dp_en(dp_en), .fnd_com(fnd_com), .fnd_font(fnd_font)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input int v, input bit bl, input logic [3:0] dp, input int i);
    logic [7:0] f;
    int p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    f = v > 9999 ? 8'hBF : (bl && i > 0 && v < p) ? 8'hFF : TBL[(v / p) % 10];
    if (dp[i]) f[7] = 1'b0;
    return f;
  endfunction

  task automatic push(input int v, input bit bl, input logic [3:0] dp);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.com  = 4'b0001 << i;
      e.com  = ~e.com;
      e.font = model(v, bl, dp, i);
      e.slot = i;
      q.push_back(e);
    end
  endtask

  task automatic wait_com(input logic [3:0] t);
    int n = 0;
    while (fnd_com !== t && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (fnd_com !== t) check("wait_com", 16'(fnd_com), 16'(t));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      check("drain", 16'(q.size()), 16'd0);
      q.delete();
    end
  endtask

  task automatic frame(input int v, input bit bl, input logic [3:0] dp, input int tear);
    wait_com(4'b0111);
    count      = 14'(v);
    blank_lead = bl;
    dp_en      = dp;
    wait_com(4'b1110);
    push(v, bl, dp);
    if (tear >= 0) begin
      wait_com(4'b1011);
      repeat (10) @(negedge clk);
      count = 14'(tear);
    end
    drain();
  endtask

  initial begin
    logic [3:0] prev;
    int cnt;
    exp_t e;
    prev = 4'hF;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cnt  = 0;
        prev = fnd_com;
      end else begin
        if (fnd_com != prev) cnt = 0;
        else cnt++;
        prev = fnd_com;
        if (cnt == 20 && q.size() > 0) begin
          e = q.pop_front();
          check($sformatf("com%0d", e.slot), 16'(fnd_com), 16'(e.com));
          check($sformatf("font%0d", e.slot), 16'(fnd_font), 16'(e.font));
        end
      end
    end
  end

  initial begin
    count = 14'd1234;
    repeat (3) @(negedge clk);
    check("rst_com", 16'(fnd_com), 16'h000F);
    check("rst_font", 16'(fnd_font), 16'h00FF);
    reset = 1'b1;
    repeat (16) @(negedge clk);
    check("pre_conv_com", 16'(fnd_com), 16'h000E);
    check("pre_conv_font", 16'(fnd_font), 16'h00C0);
    @(negedge clk);
    check("post_conv_font", 16'(fnd_font), 16'h0099);
    push(1234, 1'b0, 4'd0);
    drain();
    frame(7, 1'b1, 4'd0, -1);
    frame(0, 1'b1, 4'd0, -1);
    frame(0, 1'b0, 4'd0, -1);
    frame(12000, 1'b1, 4'd0, -1);
    frame(9999, 1'b0, 4'd0, -1);
    frame(10000, 1'b0, 4'b1000, -1);
    frame(56, 1'b0, 4'b0010, -1);
    frame(56, 1'b1, 4'b1100, -1);
    frame(1111, 1'b0, 4'd0, 2222);
    frame(2222, 1'b0, 4'd0, -1);
    for (int r = 0; r < 5; r++)
      frame(int'($urandom_range(0, 10999)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), -1);
    wait_com(4'b0111);
    count      = 14'd8765;
    blank_lead = 1'b0;
    dp_en      = 4'd0;
    wait_com(4'b1110);
    repeat (4) @(negedge clk);
    count = 14'd4321;
    reset = 1'b0;
    #1;
    check("midrst_com", 16'(fnd_com), 16'h000F);
    check("midrst_font", 16'(fnd_font), 16'h00FF);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (16) @(negedge clk);
    check("rel_com", 16'(fnd_com), 16'h000E);
    check("rel_font_old", 16'(fnd_font), 16'h00C0);
    @(negedge clk);
    check("rel_font_new", 16'(fnd_font), 16'h00F9);
    push(4321, 1'b0, 4'd0);
    drain();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
- Downstream display stage for the 14-bit up/down counter value (0..9999).
- Latches the count once per scan frame and converts it to 4 BCD digits with a sequential double-dabble FSM.
- Time-multiplexes the digits onto a 4-digit common-anode 7-segment display (FND).
- Supports optional leading-zero blanking and per-digit decimal points, e.g. a tenths point on a 10 Hz count.

Parameters:
- SCAN_DIV, 100_000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Must be >= 32.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- count  input  14  binary value to display; the valid range is 0..9999.
- blank_lead  input  1  1 = blank leading zeros.
- dp_en  input  4  per-digit decimal-point enable; bit i is digit i; active high.
- fnd_com  output  4  digit enables, active low; bit 0 = ones digit.
- fnd_font  output  8  segments {dp,g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (reset=0, asynchronous):
  - fnd_com=4'b1111 (all digits off), fnd_font=8'hFF.
  - Prescaler=0, digit index=0, BCD display registers=0, FSM=IDLE.
  - start_pending=1, so a conversion runs immediately after reset releases.
  - Reset asserted mid-conversion aborts the conversion; all state returns to reset values.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - scan_tick is asserted for one cycle when the prescaler equals SCAN_DIV-1.
- Digit index:
  - 2-bit counter that advances on scan_tick: 0->1->2->3->0.
  - A frame boundary occurs on the scan_tick where the index goes 3->0.
- Conversion FSM states: IDLE, CONV, DONE.
  - IDLE: on a frame boundary or start_pending, latch count into the shift register, clear start_pending, set bit counter=0, go to CONV.
  - CONV: one double-dabble iteration per cycle: add 3 to each BCD nibble >= 5, then shift left one bit. After 14 iterations, go to DONE.
  - DONE: copy the 4 BCD nibbles and an out-of-range flag (latched value > 9999) into the display registers; go to IDLE.
  - Latency from latch to display-register update: 16 cycles.
  - Digit 0 of a new frame shows the previous frame's value for the first 16 cycles of its slot.
  - count changes after the latch are ignored until the next frame boundary. There is no tearing within a frame.
- Font map (active low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - blank=FF, dash=BF.
- Digit selection, per current index i:
  - Out-of-range flag set: every digit shows dash. Blanking is ignored.
  - Else if blank_lead=1 and digit i is a leading zero: blank. A digit is a leading zero when i>0 and digit i and all more-significant digits are 0. The ones digit is never blanked.
  - Else: the font of BCD digit i.
  - dp_en[i]=1 forces bit 7 low. This is applied even on blanked or dash digits. dp_en is sampled live, not latched.
- Output timing:
  - fnd_com and fnd_font are registered.
  - They reflect the new index one cycle after the scan_tick that changed it.
  - fnd_com is one-hot-low: ~(4'b0001 << i).
  - Exactly one digit is enabled at any time after the first post-reset cycle.
- Width rules:
  - The BCD shift register is 16+14 bits.
  - The bit counter is 4 bits and saturates at 14.
  - The prescaler width is $clog2(SCAN_DIV).

Test Plan (SCAN_DIV=40):
- Reset: hold reset=0 with count=1234 -> fnd_com=1111, fnd_font=FF. Release reset -> within 17 cycles the display registers hold 1,2,3,4.
- Normal scan: count=1234, blank_lead=0 -> successive slots show fnd_com 1110/1101/1011/0111 with fnd_font 99/B0/A4/F9. Each slot lasts 40 cycles.
- Leading-zero blanking:
  - count=7, blank_lead=1 -> slots show F8, FF, FF, FF.
  - count=0, blank_lead=1 -> slots show C0, FF, FF, FF.
  - count=0, blank_lead=0 -> C0 on all four slots.
- Out of range and decimal point: count=12000 -> BF on all slots. count=56 with dp_en=0010 -> digit 1 shows 12 (5 with dp), digit 0 shows 82.
- No tearing: count=1111, then count=2222 in the middle of digit-2's slot -> digits 2 and 3 still show F9. At the next frame boundary plus 16 cycles, all digits show A4.
- Reset mid-conversion: drop reset 5 cycles after a frame boundary -> outputs return to 1111/FF at once. After release, a fresh conversion of the current count completes within 17 cycles.
